// File: rtl/qcw_burst_ctrl.sv
// rtl/qcw_burst_ctrl.sv - QCW burst sequencer: oscillator reset, phase ramp, hold, shutdown and cooldown
module qcw_burst_ctrl #(
    parameter int TICK_DIV       = 32,
    parameter int OSC_RST_CYCLES = 2
) (
    input  logic        clk_logic,
    input  logic        reset_n,
    input  logic        fire,
    input  logic        fault,
    input  logic        fault_clear,
    input  logic [23:0] cfg_period,
    input  logic [23:0] cfg_phase_start,
    input  logic [23:0] cfg_phase_end,
    input  logic [23:0] cfg_phase_step,
    input  logic [15:0] cfg_startup_ticks,
    input  logic [15:0] cfg_hold_ticks,
    input  logic [23:0] cfg_cooldown_ticks,
    output logic [23:0] osc_period,
    output logic [23:0] osc_phase_shift,
    output logic        osc_latch,
    output logic        osc_enable,
    output logic        osc_reset,
    output logic        busy,
    output logic        fault_latched
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_STARTUP = 3'd2;
    localparam logic [2:0] S_RAMP    = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_COOL    = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [PW-1:0] presc;
    logic [23:0]   cnt;
    logic          fire_q;
    logic          tick;
    logic          fire_rise;
    logic          entering;

    logic [23:0]   snap_end;
    logic [23:0]   snap_step;
    logic          snap_up;
    logic [23:0]   snap_startup;
    logic [23:0]   snap_hold;
    logic [23:0]   snap_cool;

    logic [23:0]   half_period;
    logic [23:0]   start_clamped;
    logic [23:0]   end_clamped;
    logic [24:0]   up_sum;
    logic [24:0]   dn_diff;
    logic [23:0]   ramp_nxt;
    logic          ramp_hit;

    // A count of n ticks is complete on the tick that brings cnt+1 up to n; n=0 completes on the first tick.
    function automatic logic ticks_done(input logic [23:0] c, input logic [23:0] n);
        return ({1'b0, c} + 25'd1) >= {1'b0, n};
    endfunction

    assign tick          = (presc == PW'(TICK_DIV - 1));
    assign fire_rise     = fire & ~fire_q;
    assign busy          = (state != S_IDLE);
    assign fault_latched = (state == S_FAULT);

    assign half_period   = cfg_period >> 1;
    assign start_clamped = (cfg_phase_start > half_period) ? half_period : cfg_phase_start;
    assign end_clamped   = (cfg_phase_end   > half_period) ? half_period : cfg_phase_end;

    // Ramp arithmetic is one bit wider so a large step saturates at the end value instead of wrapping.
    assign up_sum  = {1'b0, osc_phase_shift} + {1'b0, snap_step};
    assign dn_diff = {1'b0, osc_phase_shift} - {1'b0, snap_step};

    always_comb begin
        ramp_nxt = snap_end;
        if (snap_step != 24'd0) begin
            if (snap_up) begin
                if (up_sum < {1'b0, snap_end}) ramp_nxt = up_sum[23:0];
            end else begin
                if (!dn_diff[24] && (dn_diff[23:0] > snap_end)) ramp_nxt = dn_diff[23:0];
            end
        end
    end

    assign ramp_hit = (ramp_nxt == snap_end);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (fire_rise) state_nxt = S_ARM;
            S_ARM:     if (cnt == 24'(OSC_RST_CYCLES - 1)) state_nxt = S_STARTUP;
            S_STARTUP: if (tick && ticks_done(cnt, snap_startup)) state_nxt = S_RAMP;
            S_RAMP:    if (tick && ramp_hit) state_nxt = S_HOLD;
            S_HOLD:    if (tick && ticks_done(cnt, snap_hold)) state_nxt = S_COOL;
            S_COOL:    if (tick && ticks_done(cnt, snap_cool)) state_nxt = S_IDLE;
            S_FAULT:   if (fault_clear && !fault) state_nxt = S_COOL;
            default:   state_nxt = S_IDLE;
        endcase
        if (fault && (state != S_FAULT)) state_nxt = S_FAULT;
    end

    assign entering = (state_nxt != state);

    always_ff @(posedge clk_logic or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            presc  <= '0;
            cnt    <= '0;
            fire_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            fire_q <= fire;
            if (entering) begin
                presc <= '0;
                cnt   <= '0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick || (state == S_ARM)) cnt <= cnt + 24'd1;
            end
        end
    end

    always_ff @(posedge clk_logic or negedge reset_n) begin
        if (!reset_n) begin
            osc_period      <= '0;
            osc_phase_shift <= '0;
            osc_latch       <= 1'b0;
            osc_enable      <= 1'b0;
            osc_reset       <= 1'b0;
            snap_end        <= '0;
            snap_step       <= '0;
            snap_up         <= 1'b0;
            snap_startup    <= '0;
            snap_hold       <= '0;
            snap_cool       <= '0;
        end else begin
            osc_latch <= 1'b0;
            if (entering) begin
                case (state_nxt)
                    S_ARM: begin
                        snap_end        <= end_clamped;
                        snap_step       <= cfg_phase_step;
                        snap_up         <= (end_clamped >= start_clamped);
                        snap_startup    <= {8'd0, cfg_startup_ticks};
                        snap_hold       <= {8'd0, cfg_hold_ticks};
                        snap_cool       <= cfg_cooldown_ticks;
                        osc_period      <= cfg_period;
                        osc_phase_shift <= start_clamped;
                        osc_reset       <= 1'b1;
                    end
                    S_STARTUP: begin
                        osc_reset  <= 1'b0;
                        osc_enable <= 1'b1;
                        osc_latch  <= 1'b1;
                    end
                    S_HOLD: begin
                        osc_phase_shift <= ramp_nxt;
                        osc_latch       <= 1'b1;
                    end
                    S_COOL: begin
                        osc_enable      <= 1'b0;
                        osc_reset       <= 1'b0;
                        osc_phase_shift <= '0;
                        osc_latch       <= 1'b1;
                    end
                    S_FAULT: begin
                        osc_enable      <= 1'b0;
                        osc_reset       <= 1'b1;
                        osc_phase_shift <= '0;
                        osc_latch       <= 1'b1;
                    end
                    default: ;
                endcase
            end else if ((state == S_RAMP) && tick) begin
                osc_phase_shift <= ramp_nxt;
                osc_latch       <= 1'b1;
            end
        end
    end

endmodule
